spi_duplex_fifo: RTL and testbench

// - Parametrised TX/RX buffering between the host register interface and the SPI shift core.
// - Two independent FIFO channels: TX (host writes, core reads) and RX (core writes, host reads).
// - Each channel has a full-range occupancy count, synchronous flush and sticky overflow/underflow flags.
// - Optional watermark flags drive SPI interrupt requests.

---
 rtl/spi_fifo_pkg.sv | 17 +
 rtl/spi_fifo_channel.sv | 52 +++++
 rtl/spi_duplex_fifo.sv | 85 ++++++++
 tb/tb_spi_duplex_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared status type and pointer compare for the SPI FIFO channels.
package spi_fifo_pkg;
    localparam int MAXPW = 16;

    typedef struct packed {
        logic [MAXPW-1:0] count;
        logic             full;
        logic             empty;
        logic             overflow;
        logic             underflow;
    } fifoStatus_t;

    // x is wrPtr ^ rdPtr; returns {full, empty}
    function automatic logic [1:0] ptrCompare(input logic [MAXPW-1:0] x, input int aw);
        return {x == (MAXPW'(1) << aw), x == '0};
    endfunction
endpackage

// File: rtl/spi_fifo_channel.sv
// spi_fifo_channel: one FIFO channel with registered read, flush and sticky error flags.
module spi_fifo_channel
    import spi_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrEn,
    input  logic [DATAWIDTH-1:0] wrData,
    input  logic                 rdEn,
    output logic [DATAWIDTH-1:0] rdData,
    output logic                 rdValid,
    input  logic                 flush,
    input  logic                 errClear,
    output fifoStatus_t          status
);
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr, count;
    logic full, empty, overflow, underflow, pushOk, popOk;

    assign {full, empty} = ptrCompare(MAXPW'(wrPtr ^ rdPtr), AW);
    assign count  = wrPtr - rdPtr;
    assign pushOk = wrEn & ~full & ~flush;
    assign popOk  = rdEn & ~empty & ~flush;
    assign status = '{count: MAXPW'(count), full: full, empty: empty,
                      overflow: overflow, underflow: underflow};

    always_ff @(posedge clk)
        if (pushOk) mem[wrPtr[AW-1:0]] <= wrData;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            rdData    <= '0;
            rdValid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rdValid   <= popOk;
            if (popOk) rdData <= mem[rdPtr[AW-1:0]];
            // an error event in the same cycle as errClear keeps the flag set
            overflow  <= (overflow & ~errClear) | (wrEn & full & ~flush);
            underflow <= (underflow & ~errClear) | (rdEn & empty & ~flush);
            wrPtr     <= flush ? '0 : wrPtr + (AW+1)'(pushOk);
            rdPtr     <= flush ? '0 : rdPtr + (AW+1)'(popOk);
        end
    end
endmodule

// File: rtl/spi_duplex_fifo.sv
// spi_duplex_fifo: TX/RX buffering between host registers and the SPI core.
// Optional watermark flags enabled by defining SPI_FIFO_WATERMARK_EN.
module spi_duplex_fifo
    import spi_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int TXDEPTH   = 16,
    parameter int RXDEPTH   = 16,
    localparam int TXAW     = $clog2(TXDEPTH),
    localparam int RXAW     = $clog2(RXDEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] hostTxData,
    input  logic                 hostTxWrite,
    input  logic                 hostRxRead,
    output logic [DATAWIDTH-1:0] hostRxData,
    output logic                 hostRxValid,
    input  logic                 coreTxRead,
    output logic [DATAWIDTH-1:0] coreTxData,
    output logic                 coreTxValid,
    input  logic                 coreRxWrite,
    input  logic [DATAWIDTH-1:0] coreRxData,
    input  logic                 txFlush,
    input  logic                 rxFlush,
    input  logic                 errClear,
    output logic [TXAW:0]        txCount,
    output logic [RXAW:0]        rxCount,
    output logic                 txFull,
    output logic                 txEmpty,
    output logic                 rxFull,
    output logic                 rxEmpty,
    output logic                 txOverflow,
    output logic                 txUnderflow,
    output logic                 rxOverflow,
    output logic                 rxUnderflow,
    input  logic [TXAW:0]        txLevel,
    input  logic [RXAW:0]        rxLevel,
    output logic                 txLow,
    output logic                 rxHigh
);
    fifoStatus_t txStat, rxStat;
    logic unusedCountBits;

    spi_fifo_channel #(.DATAWIDTH(DATAWIDTH), .DEPTH(TXDEPTH)) txFifo (
        .clk(clk), .reset(reset), .wrEn(hostTxWrite), .wrData(hostTxData),
        .rdEn(coreTxRead), .rdData(coreTxData), .rdValid(coreTxValid),
        .flush(txFlush), .errClear(errClear), .status(txStat)
    );

    spi_fifo_channel #(.DATAWIDTH(DATAWIDTH), .DEPTH(RXDEPTH)) rxFifo (
        .clk(clk), .reset(reset), .wrEn(coreRxWrite), .wrData(coreRxData),
        .rdEn(hostRxRead), .rdData(hostRxData), .rdValid(hostRxValid),
        .flush(rxFlush), .errClear(errClear), .status(rxStat)
    );

    assign txCount     = txStat.count[TXAW:0];
    assign rxCount     = rxStat.count[RXAW:0];
    assign txFull      = txStat.full;
    assign txEmpty     = txStat.empty;
    assign rxFull      = rxStat.full;
    assign rxEmpty     = rxStat.empty;
    assign txOverflow  = txStat.overflow;
    assign txUnderflow = txStat.underflow;
    assign rxOverflow  = rxStat.overflow;
    assign rxUnderflow = rxStat.underflow;
    assign unusedCountBits = ^{txStat.count[MAXPW-1:TXAW+1], rxStat.count[MAXPW-1:RXAW+1]};

`ifdef SPI_FIFO_WATERMARK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txLow  <= 1'b0;
            rxHigh <= 1'b0;
        end else begin
            txLow  <= txCount <= txLevel;
            rxHigh <= rxCount >= rxLevel;
        end
    end
`else
    logic unusedLevels;
    assign unusedLevels = ^{txLevel, rxLevel};
    assign txLow  = 1'b0;
    assign rxHigh = 1'b0;
`endif
endmodule

// File: tb/tb_spi_duplex_fifo.sv
// tb_spi_duplex_fifo: directed and random checks of spi_duplex_fifo against a queue model.
module tb_spi_duplex_fifo;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    logic [DW-1:0] hostTxData = 0, coreRxData = 0, hostRxData, coreTxData;
    logic hostTxWrite = 0, hostRxRead = 0, coreTxRead = 0, coreRxWrite = 0;
    logic txFlush = 0, rxFlush = 0, errClear = 0;
    logic hostRxValid, coreTxValid;
    logic [AW:0] txCount, rxCount;
    logic [AW:0] txLevel = 1, rxLevel = 3;
    logic txFull, txEmpty, rxFull, rxEmpty;
    logic txOverflow, txUnderflow, rxOverflow, rxUnderflow, txLow, rxHigh;

    spi_duplex_fifo #(.DATAWIDTH(DW), .TXDEPTH(D), .RXDEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .hostTxData(hostTxData), .hostTxWrite(hostTxWrite),
        .hostRxRead(hostRxRead), .hostRxData(hostRxData), .hostRxValid(hostRxValid),
        .coreTxRead(coreTxRead), .coreTxData(coreTxData), .coreTxValid(coreTxValid),
        .coreRxWrite(coreRxWrite), .coreRxData(coreRxData),
        .txFlush(txFlush), .rxFlush(rxFlush), .errClear(errClear),
        .txCount(txCount), .rxCount(rxCount),
        .txFull(txFull), .txEmpty(txEmpty), .rxFull(rxFull), .rxEmpty(rxEmpty),
        .txOverflow(txOverflow), .txUnderflow(txUnderflow),
        .rxOverflow(rxOverflow), .rxUnderflow(rxUnderflow),
        .txLevel(txLevel), .rxLevel(rxLevel), .txLow(txLow), .rxHigh(rxHigh)
    );

    int nTests = 0, nFail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural model: plain queues plus the visible registered outputs
    logic [DW-1:0] txQ[$], rxQ[$];
    logic [DW-1:0] mTxD = 0, mRxD = 0;
    logic mTxV = 0, mRxV = 0, mTxOv = 0, mTxUn = 0, mRxOv = 0, mRxUn = 0, mTxLow = 0, mRxHigh = 0;

    task automatic modelReset();
        txQ.delete(); rxQ.delete();
        mTxD = 0; mRxD = 0; mTxV = 0; mRxV = 0;
        mTxOv = 0; mTxUn = 0; mRxOv = 0; mRxUn = 0; mTxLow = 0; mRxHigh = 0;
    endtask

    task automatic modelStep();
        int txN = txQ.size();
        int rxN = rxQ.size();
`ifdef SPI_FIFO_WATERMARK_EN
        mTxLow  = txN <= int'(txLevel);
        mRxHigh = rxN >= int'(rxLevel);
`endif
        mTxV = coreTxRead && txN > 0 && !txFlush;
        if (mTxV) mTxD = txQ[0];
        mRxV = hostRxRead && rxN > 0 && !rxFlush;
        if (mRxV) mRxD = rxQ[0];
        mTxOv = (mTxOv && !errClear) || (hostTxWrite && txN == D && !txFlush);
        mTxUn = (mTxUn && !errClear) || (coreTxRead && txN == 0 && !txFlush);
        mRxOv = (mRxOv && !errClear) || (coreRxWrite && rxN == D && !rxFlush);
        mRxUn = (mRxUn && !errClear) || (hostRxRead && rxN == 0 && !rxFlush);
        if (txFlush) txQ.delete();
        else begin
            if (mTxV) void'(txQ.pop_front());
            if (hostTxWrite && txN < D) txQ.push_back(hostTxData);
        end
        if (rxFlush) rxQ.delete();
        else begin
            if (mRxV) void'(rxQ.pop_front());
            if (coreRxWrite && rxN < D) rxQ.push_back(coreRxData);
        end
    endtask

    task automatic checkAll();
        check("txCount", 32'(txCount), 32'(txQ.size()));
        check("txFull", 32'(txFull), 32'(txQ.size() == D));
        check("txEmpty", 32'(txEmpty), 32'(txQ.size() == 0));
        check("txOverflow", 32'(txOverflow), 32'(mTxOv));
        check("txUnderflow", 32'(txUnderflow), 32'(mTxUn));
        check("coreTxValid", 32'(coreTxValid), 32'(mTxV));
        check("coreTxData", 32'(coreTxData), 32'(mTxD));
        check("rxCount", 32'(rxCount), 32'(rxQ.size()));
        check("rxFull", 32'(rxFull), 32'(rxQ.size() == D));
        check("rxEmpty", 32'(rxEmpty), 32'(rxQ.size() == 0));
        check("rxOverflow", 32'(rxOverflow), 32'(mRxOv));
        check("rxUnderflow", 32'(rxUnderflow), 32'(mRxUn));
        check("hostRxValid", 32'(hostRxValid), 32'(mRxV));
        check("hostRxData", 32'(hostRxData), 32'(mRxD));
        check("txLow", 32'(txLow), 32'(mTxLow));
        check("rxHigh", 32'(rxHigh), 32'(mRxHigh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic cyc(input logic tw, input logic [DW-1:0] td, input logic tr,
                       input logic rw, input logic [DW-1:0] rd, input logic rr,
                       input logic tf, input logic rf, input logic ec);
        hostTxWrite = tw; hostTxData = td; coreTxRead = tr;
        coreRxWrite = rw; coreRxData = rd; hostRxRead = rr;
        txFlush = tf; rxFlush = rf; errClear = ec;
        tick();
        {hostTxWrite, coreTxRead, coreRxWrite, hostRxRead, txFlush, rxFlush, errClear} = '0;
    endtask

    initial begin
        #12;
        checkAll();
        check("resetTxEmpty", 32'(txEmpty), 1);
        reset = 0;

        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h11 * (i + 1)), 0, 0, 0, 0, 0, 0, 0);
        check("fillCount", 32'(txCount), 4);
        check("fillFull", 32'(txFull), 1);
        cyc(1, 8'h55, 0, 0, 0, 0, 0, 0, 0);
        check("dropOvf", 32'(txOverflow), 1);
        check("dropCount", 32'(txCount), 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("clearOvf", 32'(txOverflow), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
            check("popData", 32'(coreTxData), 32'(8'h11 * (i + 1)));
            check("popValid", 32'(coreTxValid), 1);
        end
        check("drainEmpty", 32'(txEmpty), 1);

        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("rxUnd", 32'(rxUnderflow), 1);
        check("rxNoValid", 32'(hostRxValid), 0);
        cyc(0, 0, 0, 1, 8'hA5, 1, 0, 0, 0);
        check("rxPushPopCount", 32'(rxCount), 1);
        check("rxPushPopUnd", 32'(rxUnderflow), 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
        check("rxA5", 32'(hostRxData), 8'hA5);

        txLevel = 1;
        cyc(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i < 12; i++) cyc(1, 8'(i), 1, 0, 0, 0, 0, 0, 0);
        check("pairsCount", 32'(txCount), 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SPI_FIFO_WATERMARK_EN
        check("wmLowAt2", 32'(txLow), 0);
`endif
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("wmPopLag", 32'(txLow), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SPI_FIFO_WATERMARK_EN
        check("wmLowAt1", 32'(txLow), 1);
`else
        check("wmTied", 32'(txLow), 0);
`endif
        cyc(1, 8'h70, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 8'h71, 0, 0, 0, 0, 0, 0, 0);
        check("preFlushCount", 32'(txCount), 3);
        cyc(1, 8'h72, 0, 0, 0, 0, 1, 0, 0);
        check("flushCount", 32'(txCount), 0);
        check("flushEmpty", 32'(txEmpty), 1);
        check("flushOvf", 32'(txOverflow), 0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                reset = 1;
                #2;
                modelReset();
                checkAll();
                reset = 0;
            end
            if ($urandom_range(0, 15) == 0) begin
                txLevel = 3'($urandom_range(0, D));
                rxLevel = 3'($urandom_range(0, D));
            end
            cyc(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 99) < 45), 8'($urandom), 1'($urandom_range(0, 99) < 55),
                1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
